// File: rtl/heart_pattern_sequencer.sv
// rtl/heart_pattern_sequencer.sv - twelve-LED heart fill/blink/clear sequencer
//
// Purpose:
//   On start, lights LED pairs from the outside in (FILL), blinks the full
//   pattern BLINKS times (BLINK), then extinguishes pairs from the inside out
//   (CLEAR). The sequencer advances one step every STEP_CYCLES clocks.
//   A done pulse follows completion.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   start             begins a sequence when idle; ignored while busy
//   pause             level input; freezes all sequencing state while high
//   signal1..signal12 LED drives, pattern bit i drives signal(i+1)
//   phase             00 IDLE, 01 FILL, 10 BLINK, 11 CLEAR
//   busy              high whenever phase is not IDLE
//   done              one-cycle pulse after the last CLEAR step
module heart_pattern_sequencer #(
  parameter int STEP_CYCLES = 4,
  parameter int BLINKS      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  output logic       signal1,
  output logic       signal2,
  output logic       signal3,
  output logic       signal4,
  output logic       signal5,
  output logic       signal6,
  output logic       signal7,
  output logic       signal8,
  output logic       signal9,
  output logic       signal10,
  output logic       signal11,
  output logic       signal12,
  output logic [1:0] phase,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_BLINK = 2'b10,
    S_CLEAR = 2'b11
  } state_t;

  localparam logic [7:0] TICK_LAST  = 8'(STEP_CYCLES - 1);
  localparam logic [3:0] PAIR_LAST  = 4'd5;
  localparam logic [3:0] BLINK_LAST = 4'(2 * BLINKS - 1);

  state_t      r_state;
  logic [7:0]  r_tick;
  logic [3:0]  r_step;
  logic [11:0] r_pattern;
  logic        r_busy;
  logic        r_done;

  // Pair masks for the current step: FILL works outside-in, CLEAR inside-out.
  logic [11:0] w_fill_mask;
  logic [11:0] w_clear_mask;

  assign w_fill_mask  = (12'b1 << r_step) | (12'b1 << (4'd11 - r_step));
  assign w_clear_mask = (12'b1 << (4'd5 - r_step)) | (12'b1 << (4'd6 + r_step));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tick    <= 8'd0;
      r_step    <= 4'd0;
      r_pattern <= 12'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Accepted even with pause high; the tick counter then simply
          // stays at 0 until pause falls.
          if (start) begin
            r_state   <= S_FILL;
            r_busy    <= 1'b1;
            r_tick    <= 8'd0;
            r_step    <= 4'd0;
            r_pattern <= 12'd0;
          end
        end
        default: begin
          if (!pause) begin
            if (r_tick == TICK_LAST) begin
              r_tick <= 8'd0;
              r_step <= r_step + 4'd1;
              case (r_state)
                S_FILL: begin
                  r_pattern <= r_pattern | w_fill_mask;
                  if (r_step == PAIR_LAST) begin
                    r_state <= S_BLINK;
                    r_step  <= 4'd0;
                  end
                end
                S_BLINK: begin
                  r_pattern <= ~r_pattern;
                  if (r_step == BLINK_LAST) begin
                    r_state <= S_CLEAR;
                    r_step  <= 4'd0;
                  end
                end
                default: begin
                  r_pattern <= r_pattern & ~w_clear_mask;
                  if (r_step == PAIR_LAST) begin
                    r_state <= S_IDLE;
                    r_step  <= 4'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                  end
                end
              endcase
            end else begin
              r_tick <= r_tick + 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign phase    = r_state;
  assign busy     = r_busy;
  assign done     = r_done;
  assign signal1  = r_pattern[0];
  assign signal2  = r_pattern[1];
  assign signal3  = r_pattern[2];
  assign signal4  = r_pattern[3];
  assign signal5  = r_pattern[4];
  assign signal6  = r_pattern[5];
  assign signal7  = r_pattern[6];
  assign signal8  = r_pattern[7];
  assign signal9  = r_pattern[8];
  assign signal10 = r_pattern[9];
  assign signal11 = r_pattern[10];
  assign signal12 = r_pattern[11];

endmodule

// File: tb/tb_heart_pattern_sequencer.sv
// tb/tb_heart_pattern_sequencer.sv - directed self-checking bench for heart_pattern_sequencer
module tb_heart_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pause;
  logic        signal1, signal2, signal3, signal4, signal5, signal6;
  logic        signal7, signal8, signal9, signal10, signal11, signal12;
  logic [1:0]  phase;
  logic        busy;
  logic        done;
  logic [11:0] w_pat;

  int n_checks = 0;
  int n_err    = 0;
  int e        = 0;

  always #5 clk = ~clk;

  assign w_pat = {signal12, signal11, signal10, signal9, signal8, signal7,
                  signal6, signal5, signal4, signal3, signal2, signal1};

  heart_pattern_sequencer #(.STEP_CYCLES(4), .BLINKS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .signal1(signal1), .signal2(signal2), .signal3(signal3), .signal4(signal4),
    .signal5(signal5), .signal6(signal6), .signal7(signal7), .signal8(signal8),
    .signal9(signal9), .signal10(signal10), .signal11(signal11), .signal12(signal12),
    .phase(phase), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Move to 1 time unit after edge E<target> of the current run.
  task automatic go_to(input int target);
    adv(target - e);
    e = target;
  endtask

  // Pulse start so that it is sampled at the next edge, which becomes E0.
  task automatic launch();
    start = 1'b1;
    adv(1);
    e = 0;
    start = 1'b0;
  endtask

  initial begin
    int ok;
    reset = 1'b0;
    start = 1'b0;
    pause = 1'b0;

    // Reset state
    #1;
    chk("rst_pattern", 16'(w_pat), 16'h000);
    chk("rst_phase",   16'(phase), 16'h0);
    chk("rst_busy",    16'(busy),  16'h0);
    chk("rst_done",    16'(done),  16'h0);
    adv(2);
    reset = 1'b1;
    adv(3);
    chk("idle_hold_phase",   16'(phase), 16'h0);
    chk("idle_hold_pattern", 16'(w_pat), 16'h000);

    // Run A: defaults, no interruption
    launch();
    chk("A_E0_phase", 16'(phase), 16'h1);
    chk("A_E0_busy",  16'(busy),  16'h1);
    go_to(3);  chk("A_E3_pattern",  16'(w_pat), 16'h000);
    go_to(4);  chk("A_E4_pattern",  16'(w_pat), 16'h801);
    go_to(8);  chk("A_E8_pattern",  16'(w_pat), 16'hC03);
    go_to(20); chk("A_E20_pattern", 16'(w_pat), 16'hF9F);
    go_to(24); chk("A_E24_pattern", 16'(w_pat), 16'hFFF);
               chk("A_E24_phase",   16'(phase), 16'h2);
    go_to(28); chk("A_E28_pattern", 16'(w_pat), 16'h000);
    go_to(32); chk("A_E32_pattern", 16'(w_pat), 16'hFFF);
    go_to(44); chk("A_E44_phase",   16'(phase), 16'h2);
    go_to(48); chk("A_E48_pattern", 16'(w_pat), 16'hFFF);
               chk("A_E48_phase",   16'(phase), 16'h3);
    go_to(52); chk("A_E52_pattern", 16'(w_pat), 16'hF9F);
    go_to(68); chk("A_E68_pattern", 16'(w_pat), 16'h801);
    go_to(71); chk("A_E71_done",    16'(done),  16'h0);
               chk("A_E71_busy",    16'(busy),  16'h1);
    go_to(72); chk("A_E72_pattern", 16'(w_pat), 16'h000);
               chk("A_E72_phase",   16'(phase), 16'h0);
               chk("A_E72_busy",    16'(busy),  16'h0);
               chk("A_E72_done",    16'(done),  16'h1);
    go_to(73); chk("A_E73_done",    16'(done),  16'h0);

    // Run B: start re-asserted while busy must not disturb timing
    launch();
    go_to(19); start = 1'b1;
    go_to(20); start = 1'b0;
    chk("B_E20_phase",   16'(phase), 16'h1);
    go_to(24); chk("B_E24_pattern", 16'(w_pat), 16'hFFF);
               chk("B_E24_phase",   16'(phase), 16'h2);
    go_to(48); chk("B_E48_phase",   16'(phase), 16'h3);
    go_to(72); chk("B_E72_phase",   16'(phase), 16'h0);
               chk("B_E72_done",    16'(done),  16'h1);
    go_to(73); chk("B_E73_done",    16'(done),  16'h0);
               chk("B_E73_busy",    16'(busy),  16'h0);

    // Run C: pause high for edges E10..E19
    launch();
    go_to(8); chk("C_E8_pattern", 16'(w_pat), 16'hC03);
    go_to(9);
    pause = 1'b1;
    ok = 1;
    for (int i = 10; i <= 19; i++) begin
      go_to(i);
      if (w_pat !== 12'hC03 || phase !== 2'b01) ok = 0;
    end
    pause = 1'b0;
    chk("C_frozen_during_pause", 16'(ok), 16'h1);
    go_to(21); chk("C_E21_pattern", 16'(w_pat), 16'hC03);
    go_to(22); chk("C_E22_pattern", 16'(w_pat), 16'hE07);
    go_to(33); chk("C_E33_phase",   16'(phase), 16'h1);
    go_to(34); chk("C_E34_pattern", 16'(w_pat), 16'hFFF);
               chk("C_E34_phase",   16'(phase), 16'h2);
    go_to(81); chk("C_E81_done",    16'(done),  16'h0);
               chk("C_E81_phase",   16'(phase), 16'h3);
    go_to(82); chk("C_E82_pattern", 16'(w_pat), 16'h000);
               chk("C_E82_phase",   16'(phase), 16'h0);
               chk("C_E82_done",    16'(done),  16'h1);
    go_to(83); chk("C_E83_done",    16'(done),  16'h0);

    // Run D: asynchronous reset mid-sequence, no done afterwards
    launch();
    go_to(26); chk("D_E26_pattern", 16'(w_pat), 16'hFFF);
    go_to(30);
    chk("D_E30_busy", 16'(busy), 16'h1);
    reset = 1'b0;
    #2;
    chk("D_async_pattern", 16'(w_pat), 16'h000);
    chk("D_async_phase",   16'(phase), 16'h0);
    chk("D_async_busy",    16'(busy),  16'h0);
    chk("D_async_done",    16'(done),  16'h0);
    adv(2);
    reset = 1'b1;
    ok = 1;
    for (int i = 0; i < 80; i++) begin
      adv(1);
      if (done !== 1'b0 || phase !== 2'b00 || w_pat !== 12'h000) ok = 0;
    end
    chk("D_no_done_stays_idle", 16'(ok), 16'h1);

    // Run E: start and pause together in IDLE
    pause = 1'b1;
    launch();
    chk("E_E0_phase",   16'(phase), 16'h1);
    chk("E_E0_pattern", 16'(w_pat), 16'h000);
    go_to(2); pause = 1'b0;
    go_to(5); chk("E_E5_pattern", 16'(w_pat), 16'h000);
    go_to(6); chk("E_E6_pattern", 16'(w_pat), 16'h801);
    reset = 1'b0;
    adv(2);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/heart_pattern_sequencer.md
HEART_PATTERN_SEQUENCER -- requirements
Module: heart_pattern_sequencer

Interface
REQ-001 Parameter STEP_CYCLES, default 4: clock cycles per sequencer tick; legal range 2..255.
REQ-002 Parameter BLINKS, default 3: full-pattern on/off blink pairs; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low: 0 = reset asserted.
REQ-005 start  input  1  sampled each edge; starts a sequence when the block is in IDLE.
REQ-006 pause  input  1  level input; while 1, the tick counter, state, step count and outputs all hold.
REQ-007 signal1..signal12  output  1 each  LED drives; pattern bit i drives signal(i+1).
REQ-008 phase  output  2  current state: 00 IDLE, 01 FILL, 10 BLINK, 11 CLEAR.
REQ-009 busy  output  1  high whenever phase != IDLE.
REQ-010 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-011 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-012 Tick counter (8 bits) SHALL count 0..STEP_CYCLES-1 while busy and pause=0, and wrap to 0.
- A tick is the cycle in which the counter equals STEP_CYCLES-1 and pause=0.
- Pattern and step updates take effect on the edge that ends the tick cycle.
REQ-013 IDLE with start=1 at edge E0 SHALL set, at E0: phase=01, tick counter=0, step=0 and pattern=0.
REQ-014 With no pause, the k-th tick's update SHALL land at edge E0+k*STEP_CYCLES.
REQ-015 start SHALL be ignored while busy=1, with no restart and no queuing.
REQ-016 FILL: tick number s (s=0..5) SHALL set pattern bits s and 11-s, lighting the pairs in order:
- signal1/12, signal2/11, signal3/10, signal4/9, signal5/8, signal6/7.
REQ-017 The 6th FILL tick SHALL leave all 12 bits set and SHALL transition to BLINK with step=0.
REQ-018 BLINK: each tick SHALL invert all 12 bits.
- After 2*BLINKS ticks the pattern is all ones again.
- The block then transitions to CLEAR with step=0.
REQ-019 CLEAR: tick number s (s=0..5) SHALL clear bits 5-s and 6+s, in the reverse pair order from signal6/7 to signal1/12.
REQ-020 The 6th CLEAR tick SHALL:
- leave the pattern at 0;
- set phase=00 and busy=0;
- drive done=1 for exactly the following cycle.
REQ-021 Step counter SHALL be 4 bits and SHALL reset to 0 on every state transition.
REQ-022 pause=1 SHALL freeze the tick counter, step, phase and pattern; counting resumes from the frozen value when pause returns to 0.
REQ-023 start=1 and pause=1 together in IDLE SHALL be accepted (phase=01), with the tick counter held at 0 until pause falls.
REQ-024 pause SHALL have no effect in IDLE other than the hold described in REQ-023.
REQ-025 Unpaused sequence length SHALL be (12+2*BLINKS)*STEP_CYCLES cycles from E0 to the return to IDLE; this is 72 cycles at the defaults.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for clk, force the following regardless of state:
- phase=00, busy=0, done=0;
- pattern, tick counter and step all 0.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.
REQ-028 After reset deasserts, the block SHALL wait in IDLE for a new start.

Verification
REQ-029 Reset: hold reset=0 for 2 cycles, then release.
- During reset: all signalN=0, phase=00, busy=0, done=0.
- These values hold until start is applied.
REQ-030 Defaults, start pulsed at E0, FILL phase:
- E4: signal1=signal12=1, all others 0.
- E24: all 12 high, phase=10.
REQ-031 Defaults, BLINK phase:
- E28: all low.
- E32: all high.
- E48: all high, phase=11.
REQ-032 Defaults, CLEAR phase and completion:
- E52: signal6=signal7=0, all others 1.
- E72: all low, phase=00, busy=0.
- done=1 for exactly 1 cycle after E72.
REQ-033 pause=1 for 10 cycles starting at E10:
- The pattern stays frozen at 2 pairs lit for the whole pause.
- All later edges shift by 10, so done follows E82.
REQ-034 Interruptions:
- reset=0 at E30 clears all outputs before the next clk edge; no done pulse follows.
- In a separate run, start=1 at E20 while busy leaves the timing of REQ-030 to REQ-032 unchanged.
